// File: rtl/shift_pkg.sv
// Shared types and encodings for the shift sequencer and its one-bit-per-cycle register.
// Rotate support is selected by the SHIFT_SEQ_ROTATE_EN macro in the files that use this package.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic [1:0] SHIFT_LOGIC = 2'b00;
  localparam logic [1:0] SHIFT_ARITH = 2'b01;
  localparam logic [1:0] SHIFT_ROT   = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Fill-bit select understood by shift_step.
  localparam logic [1:0] FILL_ZERO = 2'd0;
  localparam logic [1:0] FILL_MSB  = 2'd1;
  localparam logic [1:0] FILL_ROT  = 2'd2;

  // Arithmetic only means sign fill on a right shift; left arithmetic and reserved are logical.
  function automatic logic [1:0] fill_sel_f(input logic [1:0] mode, input logic dir,
                                            input logic rot_en);
    logic [1:0] sel;
    sel = FILL_ZERO;
    if (mode == SHIFT_ARITH && dir == DIR_RIGHT) sel = FILL_MSB;
    else if (mode == SHIFT_ROT && rot_en)        sel = FILL_ROT;
    return sel;
  endfunction

endpackage

// File: rtl/shift_step.sv
// N-bit shift register: load, one-position step per enabled cycle, selectable fill bit.
// The rotate feedback path exists only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         en,
  input  logic         dir,
  input  logic [1:0]   fill_sel,
  output logic [N-1:0] q
);

  logic fill_bit;

  always_comb begin
    fill_bit = 1'b0;
    case (fill_sel)
      FILL_MSB: fill_bit = q[N-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      FILL_ROT: fill_bit = (dir == DIR_LEFT) ? q[N-1] : q[0];
`endif
      default:  fill_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (en) begin
      if (dir == DIR_LEFT) q <= {q[N-2:0], fill_bit};
      else                 q <= {fill_bit, q[N-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that loads shift_step, steps it the effective count, then offers the result.
// Define SHIFT_SEQ_ROTATE_EN to build rotate mode; otherwise mode 10 decodes as logical.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// cmd_ready is high only in IDLE, res_valid only in DONE, and res_data is held while
// res_valid waits for res_ready. abort (outside IDLE) and clr pre-empt any transfer.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic [AW-1:0] cmd_amt,
  input  logic          cmd_dir,
  input  logic [1:0]    cmd_mode,
  input  logic          abort,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int LW = $clog2(N);

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  shift_state_t  state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] eff_cnt;
  logic          dir_q;
  logic [1:0]    fill_q;
  logic          accept;
  logic          abort_hit;
  logic          step_en;
  logic          step_clr;
  logic [N-1:0]  reg_q;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_ready & cmd_valid;
  assign abort_hit = abort & (state_q != IDLE);
  assign step_en   = (state_q == SHIFT) && (cnt_q != '0);
  assign step_clr  = clr | abort_hit;

  // Rotating by a multiple of N is the identity, so rotate keeps only the low bits.
  always_comb begin
    eff_cnt = (cmd_amt > AW'(N)) ? AW'(N) : cmd_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (cmd_mode == SHIFT_ROT) eff_cnt = {{(AW-LW){1'b0}}, cmd_amt[LW-1:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      fill_q  <= FILL_ZERO;
    end else if (abort_hit) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= SHIFT;
            cnt_q   <= eff_cnt;
            dir_q   <= cmd_dir;
            fill_q  <= fill_sel_f(cmd_mode, cmd_dir, ROT_EN);
          end
        end
        SHIFT: begin
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - AW'(1);
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  shift_step #(.N(N)) u_step (
    .clk       (clk),
    .clr       (step_clr),
    .load      (accept),
    .load_data (cmd_data),
    .en        (step_en),
    .dir       (dir_q),
    .fill_sel  (fill_q),
    .q         (reg_q)
  );

  assign res_valid = (state_q == DONE);
  assign res_data  = reg_q;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: vector table for data/latency plus hand sequences
// for reset, backpressure, abort and mid-shift clear.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int N  = 32;
  localparam int AW = 6;
  localparam int NV = 15;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_data;
  logic [AW-1:0] cmd_amt;
  logic          cmd_dir;
  logic [1:0]    cmd_mode;
  logic          abort;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .cmd_dir   (cmd_dir),
    .cmd_mode  (cmd_mode),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [N-1:0]  data;
    logic [AW-1:0] amt;
    logic          dir;
    logic [1:0]    mode;
    logic [N-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge after the accept edge; returns edges until res_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept_cmd(input logic [N-1:0] d, input logic [AW-1:0] a,
                            input logic dr, input logic [1:0] m);
    @(negedge clk);
    cmd_data  = d;
    cmd_amt   = a;
    cmd_dir   = dr;
    cmd_mode  = m;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic deliver();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [N-1:0] got;

    vecs[0]  = '{32'h0000_00F1, 6'd4,  DIR_LEFT,  2'b00, 32'h0000_0F10, 5};
    vecs[1]  = '{32'h8000_0010, 6'd4,  DIR_RIGHT, 2'b01, 32'hF800_0001, 5};
    vecs[2]  = '{32'hA5A5_A5A5, 6'd40, DIR_LEFT,  2'b00, 32'h0000_0000, 33};
    vecs[3]  = '{32'h1234_5678, 6'd0,  DIR_LEFT,  2'b00, 32'h1234_5678, 1};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[4]  = '{32'h8000_0001, 6'd33, DIR_LEFT,  2'b10, 32'h0000_0003, 2};
    vecs[11] = '{32'h0000_0001, 6'd4,  DIR_RIGHT, 2'b10, 32'h1000_0000, 5};
    vecs[12] = '{32'hDEAD_BEEF, 6'd32, DIR_LEFT,  2'b10, 32'hDEAD_BEEF, 1};
`else
    vecs[4]  = '{32'h8000_0001, 6'd33, DIR_LEFT,  2'b10, 32'h0000_0000, 33};
    vecs[11] = '{32'h0000_0001, 6'd4,  DIR_RIGHT, 2'b10, 32'h0000_0000, 5};
    vecs[12] = '{32'hDEAD_BEEF, 6'd32, DIR_LEFT,  2'b10, 32'h0000_0000, 33};
`endif
    vecs[5]  = '{32'h8000_0000, 6'd31, DIR_RIGHT, 2'b01, 32'hFFFF_FFFF, 32};
    vecs[6]  = '{32'h8000_0010, 6'd4,  DIR_LEFT,  2'b01, 32'h0000_0100, 5};
    vecs[7]  = '{32'h8000_0010, 6'd4,  DIR_RIGHT, 2'b00, 32'h0800_0001, 5};
    vecs[8]  = '{32'hF000_0000, 6'd4,  DIR_RIGHT, 2'b11, 32'h0F00_0000, 5};
    vecs[9]  = '{32'h1234_5678, 6'd32, DIR_RIGHT, 2'b01, 32'h0000_0000, 33};
    vecs[10] = '{32'h8765_4321, 6'd32, DIR_RIGHT, 2'b01, 32'hFFFF_FFFF, 33};
    vecs[13] = '{32'h1234_5678, 6'd63, DIR_LEFT,  2'b00, 32'h0000_0000, 33};
    vecs[14] = '{32'h0000_00F1, 6'd8,  DIR_LEFT,  2'b00, 32'h0000_F100, 9};

    // Clock/reset: a handshake offered during clr must be ignored.
    clr = 1'b1; cmd_valid = 1'b0; cmd_data = 32'hCAFE_F00D; cmd_amt = '0;
    cmd_dir = DIR_RIGHT; cmd_mode = 2'b00; abort = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  res_data,       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    clr = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("clr_handshake_ignored", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) begin
      check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
      accept_cmd(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].mode);
      wait_result(lat);
      check($sformatf("v%0d_data", i), res_data, vecs[i].exp_data);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      deliver();
    end

    // Backpressure: result must hold for 10 cycles, then abort beats res_ready.
    accept_cmd(32'h0000_00F1, 6'd4, DIR_LEFT, 2'b00);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'd5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("bp_data_c%0d", c),  res_data,       32'h0000_0F10);
    end
    abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ready = 1'b0;
    check("abort_done_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_done_res_valid", 32'(res_valid), 32'd0);
    check("abort_done_res_data",  res_data,       32'd0);
    check("abort_done_busy",      32'(busy),      32'd0);

    // Abort in SHIFT clears the register and returns to IDLE.
    accept_cmd(32'hFFFF_0000, 6'd10, DIR_RIGHT, 2'b00);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_shift_state", 32'(dbg_state), 32'(IDLE));
    check("abort_shift_data",  res_data,       32'd0);

    // Abort in IDLE is ignored: the command offered with it is taken.
    @(negedge clk);
    cmd_data = 32'h0000_00F1; cmd_amt = 6'd0; cmd_dir = DIR_LEFT; cmd_mode = 2'b00;
    cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd1);
    wait_result(lat);
    check("abort_idle_data", res_data, 32'h0000_00F1);
    deliver();

    // clr at counter 12 of a 20-step shift.
    accept_cmd(32'h0F0F_0F0F, 6'd20, DIR_LEFT, 2'b00);
    repeat (8) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    check("mid_state_before", 32'(dbg_state), 32'(SHIFT));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("mid_clr_busy",      32'(busy),      32'd0);
    check("mid_clr_data",      res_data,       32'd0);
    check("mid_clr_cmd_ready", 32'(cmd_ready), 32'd1);
    accept_cmd(32'h0000_00F1, 6'd4, DIR_LEFT, 2'b00);
    wait_result(lat);
    check("post_clr_data", res_data, 32'h0000_0F10);
    check("post_clr_lat",  32'(lat), 32'd5);
    deliver();
    check("post_clr_idle", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
